mem_access_ctrl: RTL and testbench
==================================

Name: mem_access_ctrl

Overview:
- Consumer end of the EX/MEM pipeline register in the 16-bit pipelined CPU.
- Takes the registered EX/MEM control and data fields and runs the data-memory access against a variable-latency memory using a req/ack handshake.
- Stalls the upstream pipeline until the access completes, and produces the registered MEM/WB fields for writeback.
- Instructions that do not access memory pass through in one cycle with no stall.

Parameters:
- TIMEOUT, 16, maximum number of ACCESS cycles to wait for mem_ack before aborting the access.
- CNT_W, 5, width of the wait counter; must satisfy 2^CNT_W > TIMEOUT.

Ports:
- clk  in  1  pipeline clock
- rst  in  1  asynchronous, active-low reset
- q_Data_Mem_en  in  1  EX/MEM: the instruction accesses data memory
- q_Data_Mem_wr  in  1  EX/MEM: 1 = store, 0 = load
- q_from_mem  in  1  EX/MEM: writeback data comes from memory read data
- q_WriteReg  in  1  EX/MEM: register write enable
- q_hlt  in  1  EX/MEM: halt marker
- q_DstReg  in  4  EX/MEM: destination register
- q_Data_Mem_Addr  in  16  EX/MEM: memory address
- q_Data_Mem_In  in  16  EX/MEM: store data
- q_DstData  in  16  EX/MEM: ALU result
- mem_req  out  1  memory request, held until ack or timeout
- mem_wr  out  1  request is a write
- mem_addr  out  16  request address
- mem_wdata  out  16  request write data
- mem_rdata  in  16  read data, valid when mem_ack=1
- mem_ack  in  1  one-cycle completion pulse from memory
- stall  out  1  freeze upstream (drives exmem_en low)
- mem_err  out  1  sticky timeout flag
- wb_WriteReg  out  1  MEM/WB register write enable
- wb_hlt  out  1  MEM/WB halt marker
- wb_DstReg  out  4  MEM/WB destination register
- wb_DstData  out  16  MEM/WB writeback data

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE, wait counter=0, capture register=0, mem_err=0. All wb_* outputs are 0.
- stall, mem_req, mem_wr, mem_addr and mem_wdata are combinational from state and the q_* inputs.
- mem_req is 1 only in ACCESS. mem_wr, mem_addr and mem_wdata follow q_Data_Mem_wr, q_Data_Mem_Addr and q_Data_Mem_In and are valid whenever mem_req=1.
- IDLE, q_Data_Mem_en=0:
  - stall=0.
  - MEM/WB loads from EX/MEM at the clock edge: wb_WriteReg=q_WriteReg, wb_hlt=q_hlt, wb_DstReg=q_DstReg, wb_DstData=q_DstData.
- IDLE, q_Data_Mem_en=1:
  - stall=1; MEM/WB loads a bubble (wb_WriteReg=0, wb_hlt=0, wb_DstReg=0, wb_DstData=0).
  - Next state ACCESS, counter cleared.
- ACCESS:
  - mem_req=1, stall=1, MEM/WB loads a bubble each cycle.
  - mem_ack=1: capture mem_rdata, go to COMPLETE. An ack in the first ACCESS cycle is legal (1-cycle latency).
  - No ack and counter==TIMEOUT-1: set mem_err, capture 16'h0000, set the abort flag, go to COMPLETE.
  - Otherwise increment the counter.
- COMPLETE:
  - stall=0, so EX/MEM advances at this edge.
  - MEM/WB loads wb_DstReg=q_DstReg and wb_hlt=q_hlt.
  - wb_WriteReg = q_WriteReg & ~abort.
  - wb_DstData = q_from_mem ? captured data : q_DstData.
  - Next state IDLE; the abort flag clears.
- Stores (q_Data_Mem_wr=1) take the same path; read data is ignored unless q_from_mem=1.
- Minimum memory-instruction cost: 3 cycles (IDLE detect, one ACCESS, COMPLETE). Back-to-back memory instructions each re-enter ACCESS from IDLE.
- mem_ack outside ACCESS is ignored. mem_ack in the same cycle as timeout takes priority: the access is a normal completion, with no error and no abort.
- mem_err stays 1 until reset.
- A halt instruction is not special-cased; it flows to wb_hlt like any other field.
- Reset mid-access drops mem_req immediately and discards any captured data.

Decomposition:
- Shared package: state encoding (IDLE=2'b00, ACCESS=2'b01, COMPLETE=2'b10) and the bubble value constants.
- One sub-module: memwb, the MEM/WB register bank built from the existing dff, dff_4bit and dff_16bit cells with wen tied high.
- The FSM, counter and capture register stay in the top module.

Test Plan:
- Non-memory op (q_WriteReg=1, q_DstReg=4'h3, q_DstData=16'h1234): stall=0 throughout; next cycle wb_WriteReg=1, wb_DstReg=3, wb_DstData=16'h1234.
- Load, ack 1 cycle after req, mem_rdata=16'hBEEF, q_from_mem=1, q_DstReg=4'h5: stall high 2 cycles; wb_DstData=16'hBEEF, wb_DstReg=5, wb_WriteReg=1; bubbles during the stall.
- Store addr=16'h0040, data=16'hA5A5, ack after 4 cycles: mem_req high 4 cycles with mem_wr=1 and stable addr/data; wb_WriteReg=0; mem_err=0.
- No ack for TIMEOUT=16 cycles: mem_req drops after 16 ACCESS cycles; mem_err=1 and stays set; wb_WriteReg=0, wb_DstData=0.
- mem_ack on the timeout cycle: normal completion, mem_err=0, data captured.
- rst pulsed low during ACCESS: mem_req=0 and stall=0 immediately, all wb_*=0; after release a new load completes normally.

Source files
------------

// File: rtl/mem_access_ctrl_pkg.sv
// rtl/mem_access_ctrl_pkg.sv - shared state encoding and MEM/WB bubble constants
package mem_access_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE     = 2'b00,
        ACCESS   = 2'b01,
        COMPLETE = 2'b10
    } state_t;

    typedef struct packed {
        logic        write_reg;
        logic        hlt;
        logic [3:0]  dst_reg;
        logic [15:0] dst_data;
    } memwb_t;

    localparam logic        BUBBLE_WRITEREG = 1'b0;
    localparam logic        BUBBLE_HLT      = 1'b0;
    localparam logic [3:0]  BUBBLE_DSTREG   = 4'h0;
    localparam logic [15:0] BUBBLE_DSTDATA  = 16'h0000;

    localparam memwb_t BUBBLE = '{
        write_reg: BUBBLE_WRITEREG,
        hlt:       BUBBLE_HLT,
        dst_reg:   BUBBLE_DSTREG,
        dst_data:  BUBBLE_DSTDATA
    };

endpackage

// File: rtl/mem_access_ctrl_if.sv
// rtl/mem_access_ctrl_if.sv - data-memory req/ack handshake bundle
interface mem_access_ctrl_if;
    logic        mem_req;
    logic        mem_wr;
    logic [15:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;
    logic        mem_ack;

    modport master (
        output mem_req, mem_wr, mem_addr, mem_wdata,
        input  mem_rdata, mem_ack
    );

    modport slave (
        input  mem_req, mem_wr, mem_addr, mem_wdata,
        output mem_rdata, mem_ack
    );
endinterface

// File: rtl/dff.sv
// rtl/dff.sv - 1-bit register cell with write enable, async active-low reset
module dff (
    output logic q,
    input  logic d,
    input  logic wen,
    input  logic clk,
    input  logic rst
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     q <= 1'b0;
        else if (wen) q <= d;
    end
endmodule

// File: rtl/dff_16bit.sv
// rtl/dff_16bit.sv - 16-bit register cell with write enable, async active-low reset
module dff_16bit (
    output logic [15:0] q,
    input  logic [15:0] d,
    input  logic        wen,
    input  logic        clk,
    input  logic        rst
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     q <= 16'h0000;
        else if (wen) q <= d;
    end
endmodule

// File: rtl/dff_4bit.sv
// rtl/dff_4bit.sv - 4-bit register cell with write enable, async active-low reset
module dff_4bit (
    output logic [3:0] q,
    input  logic [3:0] d,
    input  logic       wen,
    input  logic       clk,
    input  logic       rst
);
    always_ff @(posedge clk or negedge rst) begin
        if (!rst)     q <= 4'h0;
        else if (wen) q <= d;
    end
endmodule

// File: rtl/mem_access_ctrl_memwb.sv
// rtl/mem_access_ctrl_memwb.sv - MEM/WB register bank, loads every cycle
module memwb
    import mem_access_ctrl_pkg::*;
(
    input  logic        clk,
    input  logic        rst,
    input  memwb_t      d,
    output logic        wb_WriteReg,
    output logic        wb_hlt,
    output logic [3:0]  wb_DstReg,
    output logic [15:0] wb_DstData
);
    dff       u_write_reg (.q(wb_WriteReg), .d(d.write_reg), .wen(1'b1), .clk(clk), .rst(rst));
    dff       u_hlt       (.q(wb_hlt),      .d(d.hlt),       .wen(1'b1), .clk(clk), .rst(rst));
    dff_4bit  u_dst_reg   (.q(wb_DstReg),   .d(d.dst_reg),   .wen(1'b1), .clk(clk), .rst(rst));
    dff_16bit u_dst_data  (.q(wb_DstData),  .d(d.dst_data),  .wen(1'b1), .clk(clk), .rst(rst));
endmodule

// File: rtl/mem_access_ctrl.sv
// rtl/mem_access_ctrl.sv - MEM stage: variable-latency data-memory access with pipeline stall
module mem_access_ctrl
    import mem_access_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 16,
    parameter int CNT_W   = 5
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               q_Data_Mem_en,
    input  logic               q_Data_Mem_wr,
    input  logic               q_from_mem,
    input  logic               q_WriteReg,
    input  logic               q_hlt,
    input  logic [3:0]         q_DstReg,
    input  logic [15:0]        q_Data_Mem_Addr,
    input  logic [15:0]        q_Data_Mem_In,
    input  logic [15:0]        q_DstData,
    mem_access_ctrl_if.master  mem,
    output logic               stall,
    output logic               mem_err,
    output logic               wb_WriteReg,
    output logic               wb_hlt,
    output logic [3:0]         wb_DstReg,
    output logic [15:0]        wb_DstData
);

    state_t             state;
    state_t             state_next;
    logic [CNT_W-1:0]   cnt;
    logic [15:0]        cap_data;
    logic               abort;
    logic               cnt_last;
    memwb_t             wb_d;

    assign cnt_last       = (cnt == CNT_W'(TIMEOUT - 1));
    assign mem.mem_wr     = q_Data_Mem_wr;
    assign mem.mem_addr   = q_Data_Mem_Addr;
    assign mem.mem_wdata  = q_Data_Mem_In;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state    <= IDLE;
            cnt      <= '0;
            cap_data <= 16'h0000;
            abort    <= 1'b0;
            mem_err  <= 1'b0;
        end else begin
            state <= state_next;
            case (state)
                IDLE: cnt <= '0;
                ACCESS: begin
                    // An ack on the final allowed cycle still counts as a normal completion.
                    if (mem.mem_ack) begin
                        cap_data <= mem.mem_rdata;
                    end else if (cnt_last) begin
                        cap_data <= 16'h0000;
                        abort    <= 1'b1;
                        mem_err  <= 1'b1;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end
                COMPLETE: abort <= 1'b0;
                default: ;
            endcase
        end
    end

    always_comb begin
        state_next   = state;
        stall        = 1'b0;
        mem.mem_req  = 1'b0;
        wb_d         = BUBBLE;
        case (state)
            IDLE: begin
                if (q_Data_Mem_en) begin
                    stall      = 1'b1;
                    state_next = ACCESS;
                end else begin
                    wb_d = '{write_reg: q_WriteReg, hlt: q_hlt,
                             dst_reg: q_DstReg, dst_data: q_DstData};
                end
            end
            ACCESS: begin
                stall       = 1'b1;
                mem.mem_req = 1'b1;
                if (mem.mem_ack || cnt_last) state_next = COMPLETE;
            end
            COMPLETE: begin
                wb_d = '{write_reg: q_WriteReg & ~abort, hlt: q_hlt,
                         dst_reg: q_DstReg,
                         dst_data: q_from_mem ? cap_data : q_DstData};
                state_next = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    memwb u_memwb (
        .clk         (clk),
        .rst         (rst),
        .d           (wb_d),
        .wb_WriteReg (wb_WriteReg),
        .wb_hlt      (wb_hlt),
        .wb_DstReg   (wb_DstReg),
        .wb_DstData  (wb_DstData)
    );

endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb/tb_mem_access_ctrl.sv - scoreboard bench for mem_access_ctrl
module tb_mem_access_ctrl;

    localparam int TMO = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        q_Data_Mem_en = 1'b0, q_Data_Mem_wr = 1'b0, q_from_mem = 1'b0;
    logic        q_WriteReg = 1'b0, q_hlt = 1'b0;
    logic [3:0]  q_DstReg = 4'h0;
    logic [15:0] q_Data_Mem_Addr = 16'h0, q_Data_Mem_In = 16'h0, q_DstData = 16'h0;
    logic        stall, mem_err, wb_WriteReg, wb_hlt;
    logic [3:0]  wb_DstReg;
    logic [15:0] wb_DstData;

    mem_access_ctrl_if mif();

    mem_access_ctrl #(.TIMEOUT(TMO), .CNT_W(5)) dut (
        .clk(clk), .rst(rst),
        .q_Data_Mem_en(q_Data_Mem_en), .q_Data_Mem_wr(q_Data_Mem_wr),
        .q_from_mem(q_from_mem), .q_WriteReg(q_WriteReg), .q_hlt(q_hlt),
        .q_DstReg(q_DstReg), .q_Data_Mem_Addr(q_Data_Mem_Addr),
        .q_Data_Mem_In(q_Data_Mem_In), .q_DstData(q_DstData),
        .mem(mif), .stall(stall), .mem_err(mem_err),
        .wb_WriteReg(wb_WriteReg), .wb_hlt(wb_hlt),
        .wb_DstReg(wb_DstReg), .wb_DstData(wb_DstData)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic        hlt;
        logic [3:0]  dst;
        logic [15:0] data;
        logic        err;
    } wb_exp_t;

    typedef struct {
        int          lat;
        logic [15:0] rdata;
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wdata;
    } acc_t;

    wb_exp_t wb_q[$];
    acc_t    acc_q[$];
    int      tests = 0;
    int      fails = 0;
    logic    exp_err = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: a memory op stalls for the detect cycle plus one cycle per wait,
    // capped at TMO waits; each stalled edge loads a bubble.
    task automatic issue(input logic en, input logic wr, input logic fm, input logic wreg,
                         input logic hlt, input logic [3:0] dst, input logic [15:0] addr,
                         input logic [15:0] wdata, input logic [15:0] dstdata,
                         input int lat, input logic [15:0] rdata);
        logic s;
        logic ok;
        int   n;
        bit   done;
        @(negedge clk);
        q_Data_Mem_en = en; q_Data_Mem_wr = wr; q_from_mem = fm; q_WriteReg = wreg;
        q_hlt = hlt; q_DstReg = dst; q_Data_Mem_Addr = addr; q_Data_Mem_In = wdata;
        q_DstData = dstdata;
        if (en) begin
            ok = (lat <= TMO);
            n  = 1 + (ok ? lat : TMO);
            for (int k = 0; k < n; k++)
                wb_q.push_back('{1'b0, 1'b0, 4'h0, 16'h0,
                                 exp_err | (!ok && k == n - 1)});
            exp_err = exp_err | !ok;
            wb_q.push_back('{wreg & ok, hlt, dst,
                             fm ? (ok ? rdata : 16'h0000) : dstdata, exp_err});
            acc_q.push_back('{lat, rdata, wr, addr, wdata});
        end else begin
            wb_q.push_back('{wreg, hlt, dst, dstdata, exp_err});
        end
        done = 1'b0;
        for (int c = 0; c < 64 && !done; c++) begin
            #1 s = stall;
            @(posedge clk);
            if (!s) done = 1'b1;
        end
        if (!done) begin
            tests++; fails++;
            $display("FAIL issue_timeout: stall never released");
        end
    endtask

    task automatic go_idle();
        @(negedge clk);
        q_Data_Mem_en = 1'b0; q_WriteReg = 1'b0; q_hlt = 1'b0;
        q_DstReg = 4'h0; q_DstData = 16'h0;
    endtask

    task automatic drain();
        for (int c = 0; c < 200 && wb_q.size() > 0; c++) @(posedge clk);
        if (wb_q.size() > 0) begin
            tests++; fails++;
            $display("FAIL drain: %0d entries left", wb_q.size());
        end
    endtask

    // Monitor: compare the MEM/WB bank after every edge while work is outstanding.
    initial begin
        wb_exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst && wb_q.size() > 0) begin
                e = wb_q.pop_front();
                check("wb_WriteReg", 32'(wb_WriteReg), 32'(e.wr));
                check("wb_hlt",      32'(wb_hlt),      32'(e.hlt));
                check("wb_DstReg",   32'(wb_DstReg),   32'(e.dst));
                check("wb_DstData",  32'(wb_DstData),  32'(e.data));
                check("mem_err",     32'(mem_err),     32'(e.err));
            end
        end
    end

    // Memory responder: acks on the chosen request cycle, random noise otherwise.
    initial begin
        acc_t cur;
        int   cyc;
        cyc = 0;
        cur = '{0, 16'h0, 1'b0, 16'h0, 16'h0};
        mif.mem_ack   = 1'b0;
        mif.mem_rdata = 16'h0;
        forever begin
            @(negedge clk);
            if (mif.mem_req) begin
                if (cyc == 0) begin
                    if (acc_q.size() == 0) begin
                        tests++; fails++;
                        $display("FAIL unexpected_req: mem_req with no access pending");
                        cur = '{0, 16'h0, mif.mem_wr, mif.mem_addr, mif.mem_wdata};
                    end else begin
                        cur = acc_q.pop_front();
                    end
                end
                cyc++;
                check("mem_wr",    32'(mif.mem_wr),    32'(cur.wr));
                check("mem_addr",  32'(mif.mem_addr),  32'(cur.addr));
                check("mem_wdata", 32'(mif.mem_wdata), 32'(cur.wdata));
                if (cyc > TMO) begin
                    tests++; fails++;
                    $display("FAIL req_too_long: cycle %0d exceeds %0d", cyc, TMO);
                end
                mif.mem_ack   = (cyc == cur.lat);
                mif.mem_rdata = (cyc == cur.lat) ? cur.rdata : 16'($urandom);
            end else begin
                cyc = 0;
                mif.mem_ack   = ($urandom_range(0, 3) == 0);
                mif.mem_rdata = 16'($urandom);
            end
        end
    end

    initial begin
        int r;
        int lat;
        #1;
        check("rst_wb_WriteReg", 32'(wb_WriteReg), 32'h0);
        check("rst_wb_DstData",  32'(wb_DstData),  32'h0);
        check("rst_wb_DstReg",   32'(wb_DstReg),   32'h0);
        check("rst_mem_req",     32'(mif.mem_req), 32'h0);
        check("rst_mem_err",     32'(mem_err),     32'h0);
        check("rst_stall",       32'(stall),       32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;

        // Directed cases: ALU op, 1-cycle load, 4-cycle store, timeout, ack on timeout cycle.
        issue(0, 0, 0, 1, 0, 4'h3, 16'h0,    16'h0,    16'h1234, 0,  16'h0);
        issue(1, 0, 1, 1, 0, 4'h5, 16'h0010, 16'h0,    16'h7777, 1,  16'hBEEF);
        issue(1, 1, 0, 0, 0, 4'h0, 16'h0040, 16'hA5A5, 16'h0040, 4,  16'h1111);
        issue(1, 0, 1, 1, 0, 4'h9, 16'h0080, 16'h0,    16'h2222, 99, 16'h0);
        issue(0, 0, 0, 1, 1, 4'hF, 16'h0,    16'h0,    16'hFFFF, 0,  16'h0);
        issue(1, 0, 1, 1, 0, 4'h6, 16'h0090, 16'h0,    16'h3333, TMO, 16'hC0DE);

        for (int i = 0; i < 150; i++) begin
            r = $urandom_range(0, 9);
            lat = (r < 6) ? $urandom_range(1, 5) : (r == 6) ? TMO : (r == 7) ? TMO - 1 : TMO + 1;
            issue(1'($urandom_range(0, 2) != 0), 1'($urandom), 1'($urandom), 1'($urandom),
                  1'($urandom_range(0, 7) == 0), 4'($urandom), 16'($urandom),
                  16'($urandom), 16'($urandom), lat, 16'($urandom));
        end
        go_idle();
        drain();

        // Reset in the middle of an access.
        @(negedge clk);
        q_Data_Mem_en = 1'b1; q_Data_Mem_wr = 1'b0; q_from_mem = 1'b1; q_WriteReg = 1'b1;
        q_DstReg = 4'h7; q_Data_Mem_Addr = 16'h0123; q_Data_Mem_In = 16'h0;
        acc_q.push_back('{99, 16'h0, 1'b0, 16'h0123, 16'h0});
        repeat (3) @(negedge clk);
        check("pre_rst_mem_req", 32'(mif.mem_req), 32'h1);
        #2;
        q_Data_Mem_en = 1'b0;
        rst = 1'b0;
        exp_err = 1'b0;
        #1;
        check("mid_rst_mem_req",     32'(mif.mem_req), 32'h0);
        check("mid_rst_stall",       32'(stall),       32'h0);
        check("mid_rst_wb_WriteReg", 32'(wb_WriteReg), 32'h0);
        check("mid_rst_wb_DstReg",   32'(wb_DstReg),   32'h0);
        check("mid_rst_wb_DstData",  32'(wb_DstData),  32'h0);
        check("mid_rst_mem_err",     32'(mem_err),     32'h0);
        repeat (2) @(negedge clk);
        rst = 1'b1;
        acc_q.delete();
        issue(1, 0, 1, 1, 0, 4'hA, 16'h0200, 16'h0, 16'h4444, 2, 16'h5A5A);
        issue(0, 0, 0, 1, 0, 4'h2, 16'h0,    16'h0, 16'h0F0F, 0, 16'h0);
        go_idle();
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: simulation did not complete");
        $fatal(1, "global timeout");
    end

endmodule
